// File: rtl/csr_bank.sv
// csr_bank: addressable control/status register bank for the convolution
// accelerator. Addr 0 is a write-only command register (start/commit),
// addr 1 a sticky write-1-to-clear status register, and addr 2..NREG-1 are
// double-buffered configuration registers (bus-side shadow, datapath-side
// active). Active copies only change on a commit taken while hw_busy is low.
module csr_bank #(
  parameter int WIDTH  = 32,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_valid,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_data_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_err,
  input  logic                    hw_busy,
  input  logic [WIDTH-1:0]        hw_event,
  output logic                    start_pulse,
  output logic                    commit_done,
  output logic [(NREG-2)*WIDTH-1:0] cfg_active
);

  localparam int          NCFG   = NREG - 2;
  localparam logic [31:0] NREG_U = NREG;

  // IDLE: no deferred commit; PEND: commit requested while datapath busy
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q [NCFG];
  logic [WIDTH-1:0] shadow_d [NCFG];
  logic [WIDTH-1:0] active_q [NCFG];
  logic [WIDTH-1:0] active_d [NCFG];
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             start_pulse_q, start_pulse_d;
  logic             commit_done_q, commit_done_d;
  logic             rd_data_valid_q, rd_data_valid_d;
  logic             rd_err_q, rd_err_d;

  logic        pending;
  logic        wr_fire;
  logic        ctrl_wr;
  logic        go_pend;
  logic        cfg_commit;
  logic [31:0] wr_addr_x;
  logic [31:0] rd_addr_x;

  assign pending   = (state_q == PEND);
  assign wr_ready  = ~pending;
  assign wr_fire   = wr_valid & ~pending;
  assign wr_addr_x = 32'(wr_addr);
  assign rd_addr_x = 32'(rd_addr);
  assign ctrl_wr   = wr_fire & (wr_addr_x == 32'd0);
  // A commit is deferred only when the datapath is busy at the request.
  assign go_pend   = ctrl_wr & wr_data[1] & hw_busy;
  // Take a commit now, or complete a deferred one once busy drops.
  // Writes are stalled while pending, so shadow is stable during PEND.
  assign cfg_commit = ~hw_busy & ((ctrl_wr & wr_data[1]) | pending);

  // Commit FSM next state, sticky status and one-cycle datapath strobes
  always_comb begin
    state_d = state_q;
    if (go_pend) begin
      state_d = PEND;
    end else if (pending && !hw_busy) begin
      state_d = IDLE;
    end
    // hw_event is ORed last so a same-cycle set beats a W1C clear
    status_d = status_q | hw_event;
    if (wr_fire && (wr_addr_x == 32'd1)) begin
      status_d = (status_q & ~wr_data) | hw_event;
    end
    // Start is dropped while busy; with busy low a commit is never deferred
    start_pulse_d = ctrl_wr & wr_data[0] & ~hw_busy;
    commit_done_d = cfg_commit;
  end

  // Shadow copies take bus writes; active copies snapshot shadow on commit
  always_comb begin
    for (int k = 0; k < NCFG; k++) begin
      shadow_d[k] = shadow_q[k];
      if (wr_fire && (wr_addr_x == 32'(k + 2))) begin
        shadow_d[k] = wr_data;
      end
      active_d[k] = cfg_commit ? shadow_q[k] : active_q[k];
    end
  end

  // Read response: registered one cycle after request, sees pre-write state
  always_comb begin
    rd_data_valid_d = rd_valid;
    rd_data_d       = rd_data_q;
    rd_err_d        = rd_err_q;
    if (rd_valid) begin
      rd_err_d  = 1'b0;
      rd_data_d = '0;
      if (rd_addr_x >= NREG_U) begin
        rd_err_d = 1'b1;
      end else if (rd_addr_x == 32'd0) begin
        rd_data_d[1] = pending;
      end else if (rd_addr_x == 32'd1) begin
        rd_data_d = status_q;
      end else begin
        for (int k = 0; k < NCFG; k++) begin
          if (rd_addr_x == 32'(k + 2)) begin
            rd_data_d = shadow_q[k];
          end
        end
      end
    end
  end

  // All state registers, including the commit FSM, with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      status_q        <= '0;
      rd_data_q       <= '0;
      start_pulse_q   <= 1'b0;
      commit_done_q   <= 1'b0;
      rd_data_valid_q <= 1'b0;
      rd_err_q        <= 1'b0;
      for (int k = 0; k < NCFG; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q         <= state_d;
      status_q        <= status_d;
      rd_data_q       <= rd_data_d;
      start_pulse_q   <= start_pulse_d;
      commit_done_q   <= commit_done_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_err_q        <= rd_err_d;
      shadow_q        <= shadow_d;
      active_q        <= active_d;
    end
  end

  assign start_pulse   = start_pulse_q;
  assign commit_done   = commit_done_q;
  assign rd_data_valid = rd_data_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_err        = rd_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_cfg
      assign cfg_active[gi*WIDTH +: WIDTH] = active_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_csr_bank.sv
// tb_csr_bank: directed stimulus for csr_bank with an address-indexed
// register-file model checked against the DUT on every cycle, plus literal
// expectations at the key points of each scenario.
module tb_csr_bank;

  localparam int W      = 32;
  localparam int NREG   = 8;
  localparam int ADDR_W = 4;
  localparam int NCFG   = NREG - 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      wr_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data_valid;
  logic [W-1:0]      rd_data;
  logic              rd_err;
  logic              hw_busy;
  logic [W-1:0]      hw_event;
  logic              start_pulse;
  logic              commit_done;
  logic [NCFG*W-1:0] cfg_active;

  csr_bank #(.WIDTH(W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_err(rd_err),
    .hw_busy(hw_busy), .hw_event(hw_event),
    .start_pulse(start_pulse), .commit_done(commit_done), .cfg_active(cfg_active)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Registers indexed by bus address; active copies likewise.
  logic [W-1:0] m_reg [16];
  logic [W-1:0] m_act [16];
  logic [W-1:0] m_status;
  logic         m_pending;
  bit           m_init = 1'b0;
  logic         e_start, e_commit_done, e_rvalid, e_rerr;
  logic [W-1:0] e_rdata;
  logic [NCFG*W-1:0] e_cfg;

  logic m_acc, m_ctrl, m_commit_now, m_start, m_goes_pend;
  assign m_acc        = wr_valid && !m_pending;
  assign m_ctrl       = m_acc && (wr_addr == 0);
  assign m_commit_now = !hw_busy && ((m_ctrl && wr_data[1]) || m_pending);
  assign m_start      = m_ctrl && wr_data[0] && !hw_busy;
  assign m_goes_pend  = m_ctrl && wr_data[1] && hw_busy;

  always_comb begin
    e_cfg = '0;
    for (int k = 0; k < NCFG; k++) e_cfg[k*W +: W] = m_act[k+2];
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_init        <= 1'b1;
      m_status      <= '0;
      m_pending     <= 1'b0;
      e_start       <= 1'b0;
      e_commit_done <= 1'b0;
      e_rvalid      <= 1'b0;
      e_rerr        <= 1'b0;
      e_rdata       <= '0;
      for (int i = 0; i < 16; i++) begin
        m_reg[i] <= '0;
        m_act[i] <= '0;
      end
    end else begin
      if (m_acc && wr_addr >= 2 && wr_addr < NREG) m_reg[wr_addr] <= wr_data;
      if (m_commit_now)
        for (int i = 2; i < NREG; i++) m_act[i] <= m_reg[i];
      if (m_acc && wr_addr == 1) m_status <= (m_status & ~wr_data) | hw_event;
      else                       m_status <= m_status | hw_event;
      m_pending     <= m_goes_pend || (m_pending && hw_busy);
      e_commit_done <= m_commit_now;
      e_start       <= m_start;
      e_rvalid      <= rd_valid;
      if (rd_valid) begin
        if (rd_addr >= NREG) begin
          e_rerr  <= 1'b1;
          e_rdata <= '0;
        end else begin
          e_rerr <= 1'b0;
          if (rd_addr == 0)      e_rdata <= {30'b0, m_pending, 1'b0};
          else if (rd_addr == 1) e_rdata <= m_status;
          else                   e_rdata <= m_reg[rd_addr];
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        cmp("wr_ready", 256'(wr_ready), 256'(!m_pending));
        cmp("start_pulse", 256'(start_pulse), 256'(e_start));
        cmp("commit_done", 256'(commit_done), 256'(e_commit_done));
        cmp("rd_data_valid", 256'(rd_data_valid), 256'(e_rvalid));
        cmp("rd_data", 256'(rd_data), 256'(e_rdata));
        cmp("cfg_active", 256'(cfg_active), 256'(e_cfg));
        if (e_rvalid) cmp("rd_err", 256'(rd_err), 256'(e_rerr));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
    $display("TX write addr=%0d data=%h busy=%0b", a, d, hw_busy);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    cyc(1);
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [W-1:0] d, output logic e);
    rd_valid = 1'b1;
    rd_addr  = a;
    cyc(1);
    rd_valid = 1'b0;
    d = rd_data;
    e = rd_err;
    $display("TX read  addr=%0d data=%h err=%0b", a, d, e);
  endtask

  logic [W-1:0] rdv;
  logic         rde;
  logic [W-1:0] cfg_hi;

  initial begin
    rstn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; hw_busy = 1'b0; hw_event = '0;
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 32'hFFFF_FFFF; // ignored in reset
    cyc(2);
    wr_valid = 1'b0;
    rstn = 1'b1;
    cmp("reset wr_ready", 256'(wr_ready), 256'(1));
    cmp("reset cfg_active", 256'(cfg_active), 256'(0));
    cmp("reset rd_data_valid", 256'(rd_data_valid), 256'(0));

    // Back-to-back reads of 0..8 after reset
    for (int a = 0; a <= 8; a++) begin
      rd_valid = 1'b1;
      rd_addr  = 4'(a);
      cyc(1);
      $display("TX read  addr=%0d data=%h err=%0b", a, rd_data, rd_err);
      cmp("reset rd valid", 256'(rd_data_valid), 256'(1));
      cmp("reset rd data", 256'(rd_data), 256'(0));
      cmp("reset rd err", 256'(rd_err), 256'(a >= 8 ? 1 : 0));
    end
    rd_valid = 1'b0;

    // Shadow write, then immediate commit
    wr(4'd2, 32'hA5A5_0001);
    cmp("cfg unchanged by shadow wr", 256'(cfg_active[31:0]), 256'(0));
    wr(4'd0, 32'h2);
    cmp("commit cfg2", 256'(cfg_active[31:0]), 256'(32'hA5A5_0001));
    cmp("commit_done pulse", 256'(commit_done), 256'(1));
    cyc(1);
    cmp("commit_done single", 256'(commit_done), 256'(0));

    // Deferred commit while busy, with a stalled CFG write
    hw_busy = 1'b1;
    wr(4'd0, 32'h2);
    cmp("pend wr_ready", 256'(wr_ready), 256'(0));
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_1234;
    rd(4'd0, rdv, rde);
    cmp("ctrl readback pending", 256'(rdv), 256'(32'h2));
    cyc(3);
    hw_busy = 1'b0;
    cyc(1);
    cmp("deferred commit_done", 256'(commit_done), 256'(1));
    cmp("wr_ready after commit", 256'(wr_ready), 256'(1));
    cyc(1);
    wr_valid = 1'b0;
    rd(4'd3, rdv, rde);
    cmp("stalled write landed", 256'(rdv), 256'(32'h0000_1234));
    cfg_hi = cfg_active[63:32];
    cmp("stalled write not active", 256'(cfg_hi), 256'(0));

    // Sticky status with W1C and same-cycle set priority
    hw_event = 32'h5;
    cyc(1);
    hw_event = '0;
    rd(4'd1, rdv, rde);
    cmp("status set", 256'(rdv), 256'(32'h5));
    hw_event = 32'h1;
    wr(4'd1, 32'h1);
    hw_event = '0;
    rd(4'd1, rdv, rde);
    cmp("status set beats clear", 256'(rdv), 256'(32'h5));
    wr(4'd1, 32'h4);
    rd(4'd1, rdv, rde);
    cmp("status w1c", 256'(rdv), 256'(32'h1));

    // Start with commit: new config visible while start_pulse is high
    wr(4'd3, 32'h0000_BEEF);
    wr(4'd0, 32'h3);
    cmp("start_pulse", 256'(start_pulse), 256'(1));
    cfg_hi = cfg_active[63:32];
    cmp("cfg at start", 256'(cfg_hi), 256'(32'h0000_BEEF));
    cyc(1);
    cmp("start_pulse single", 256'(start_pulse), 256'(0));
    hw_busy = 1'b1;
    wr(4'd0, 32'h1);
    cmp("start ignored busy", 256'(start_pulse), 256'(0));
    cmp("start busy no pend", 256'(wr_ready), 256'(1));
    hw_busy = 1'b0;

    // Read and write to the same address in one cycle
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 32'h0000_0077;
    rd(4'd2, rdv, rde);
    wr_valid = 1'b0;
    cmp("read pre-write value", 256'(rdv), 256'(32'hA5A5_0001));
    rd(4'd2, rdv, rde);
    cmp("read post-write value", 256'(rdv), 256'(32'h0000_0077));

    // Out-of-range write discarded, read flags error
    wr(4'd9, 32'hDEAD_BEEF);
    rd(4'd9, rdv, rde);
    cmp("oor rd_err", 256'(rde), 256'(1));
    cmp("oor rd_data", 256'(rdv), 256'(0));

    // Reset while a commit is pending
    hw_busy = 1'b1;
    wr(4'd0, 32'h2);
    cyc(2);
    rstn = 1'b0;
    cyc(1);
    hw_busy = 1'b0;
    rstn = 1'b1;
    cmp("rst pend wr_ready", 256'(wr_ready), 256'(1));
    cmp("rst pend commit_done", 256'(commit_done), 256'(0));
    cmp("rst pend cfg_active", 256'(cfg_active), 256'(0));
    cyc(3);
    cmp("no late commit_done", 256'(commit_done), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Parametrised control/status register bank for the convolution accelerator. It replaces single-register CSR instances with one addressable block.
- Holds a control register, a sticky write-1-to-clear status register, and NREG-2 double-buffered configuration registers.
- Configuration registers have a shadow copy (bus side) and an active copy (datapath side). Active copies update only on an explicit commit while the datapath is idle.
- Sits between the host-side register bus and the accelerator datapath/controller.

Parameters:
- WIDTH, 32, register width in bits (>=2).
- NREG, 8, total registers (>=3): addr 0 = CTRL, addr 1 = STATUS, addr 2..NREG-1 = CFG.
- ADDR_W, 3, address width; 2^ADDR_W >= NREG.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset, sampled on rising clk.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid&wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_valid  in  1  read request, always accepted.
- rd_addr  in  ADDR_W  read address.
- rd_data_valid  out  1  read response strobe.
- rd_data  out  WIDTH  read response data.
- rd_err  out  1  response is for an out-of-range address; qualified by rd_data_valid.
- hw_busy  in  1  datapath busy.
- hw_event  in  WIDTH  one-cycle status set bits from datapath.
- start_pulse  out  1  one-cycle datapath start.
- commit_done  out  1  one-cycle strobe: active copies updated.
- cfg_active  out  (NREG-2)*WIDTH  active CFG copies; CFG k at bits [k*WIDTH +: WIDTH].

Behaviour:
- Reset (rstn=0 at posedge): all shadow, active, STATUS and pending state cleared to 0.
  - start_pulse, commit_done, rd_data_valid, rd_err, rd_data = 0. cfg_active = 0.
  - Bus requests in reset cycles are ignored.
  - An in-flight pending commit is dropped with no commit_done.
- wr_ready = ~pending (combinational); equals 1 out of reset.
- A write is accepted in any cycle with wr_valid & wr_ready. Writes while pending are stalled, not dropped.
- CFG write (addr 2..NREG-1): shadow updated at that posedge. Active copies are unchanged.
- STATUS write: next = (STATUS & ~wr_data) | hw_event. A set from hw_event wins over a clear in the same cycle.
  - Without a write, next = STATUS | hw_event.
- CTRL write:
  - bit0 = start. bit1 = commit. Other bits ignored. CTRL is not stored.
  - commit=1 with hw_busy=0 in the accept cycle: active<=shadow at that edge; commit_done=1 next cycle.
  - commit=1 with hw_busy=1: pending<=1. Each cycle with pending=1 and hw_busy=0: active<=shadow, pending<=0, commit_done=1 next cycle.
  - start=1 with hw_busy=0 and no commit going pending: start_pulse=1 for exactly the next cycle.
  - start=1 with hw_busy=1: start is ignored, with no side effect.
  - start+commit together with hw_busy=0: active updates and start_pulse asserts in the same cycle, so the datapath sees new config at start.
- Out-of-range write address (>=NREG): accepted and discarded.
- Read: rd_data_valid=1 exactly one cycle after rd_valid.
  - rd_data = CFG shadow, or STATUS, or CTRL readback {pending in bit1, 0 elsewhere}.
  - Out-of-range address: rd_data=0, rd_err=1.
  - Otherwise rd_err=0. rd_data holds its last value when rd_data_valid=0.
- Read and accepted write to the same address in the same cycle: the read returns the pre-write value.
- Back-to-back reads every cycle are supported (throughput 1/cycle).
- State machine: IDLE (pending=0) and PEND (pending=1).
  - IDLE->PEND on commit while busy.
  - PEND->IDLE when hw_busy=0.
  - Any state->IDLE on reset.

Test Plan:
- Reset then read addrs 0..7 -> each rd_data_valid one cycle later, data 0, rd_err=0. Read addr 8 with ADDR_W=4, NREG=8 -> rd_err=1, data 0.
- Write CFG2=0xA5A5_0001 -> cfg_active unchanged. CTRL=0x2 with hw_busy=0 -> cfg_active[0 +: 32]=0xA5A5_0001, commit_done pulse one cycle later.
- hw_busy=1, CTRL=0x2 -> wr_ready=0. A second CFG write stalls. CTRL read shows bit1=1. Drop hw_busy after 5 cycles -> commit_done once, wr_ready=1, stalled write then lands in shadow only.
- hw_event=0x0000_0005 pulse -> STATUS=0x5. Write STATUS 0x1 while hw_event=0x1 -> STATUS stays 0x5. Write 0x4 next -> STATUS=0x1.
- CTRL=0x3 with hw_busy=0 -> start_pulse and new cfg_active in same cycle, single-cycle pulse. CTRL=0x1 with hw_busy=1 -> no start_pulse.
- Assert rstn=0 during PEND -> pending cleared, no commit_done, wr_ready=1, cfg_active=0 after release.
